magic_nor_sequencer: RTL and testbench
======================================

// Module: magic_nor_sequencer
// PURPOSE
//  Sequences a stored program of MAGIC NOR operations onto a memristive crossbar. Each
//  NOR-only netlist gate becomes one instruction. Each instruction issues two crossbar
//  commands in order: INIT (set dst cell to logic 1), then EVAL (dst = NOR of 1..3 src cells).
//  Sits between the host/program loader and the crossbar row/column driver.
// PARAMETERS
//  AW   6   crossbar cell address width (2**AW cells)
//  PD   32  program depth in instructions; PAW = $clog2(PD); IW = 3 + 4*AW
// PORTS
//  clk         in   1    single clock, rising edge
//  rst         in   1    synchronous, active-high reset
//  prog_we     in   1    program write strobe (ignored while busy)
//  prog_addr   in   PAW  program write address
//  prog_wdata  in   IW   {src2,src1,src0,dst,nsrc[1:0],op}; op 1=NOR, 0=HALT
//  start       in   1    1-cycle pulse: run program from pc=0 (ignored while busy)
//  busy        out  1    high from cycle after start until done
//  done        out  1    1-cycle pulse at end of run
//  err         out  1    sticky: nsrc==0 decoded; cleared by next accepted start
//  pc          out  PAW  current instruction index
//  cmd_valid   out  1    crossbar command valid
//  cmd_ready   in   1    crossbar accepts command when valid&ready
//  cmd_type    out  1    0=INIT, 1=EVAL
//  cmd_dst     out  AW   destination cell
//  cmd_src0..2 out  AW   source cells; src1/src2 don't-care beyond nsrc
//  cmd_nsrc    out  2    1=NOT, 2=NOR2, 3=NOR3
//  stall_cnt   out  16   cycles with cmd_valid&!cmd_ready (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, err, cmd_valid, cmd_type, pc, stall_cnt = 0;
//   cmd_* address fields = 0. Program memory contents are not reset.
//  States: IDLE -> FETCH -> DECODE -> INIT -> EVAL -> FETCH ... -> DONE -> IDLE.
//  IDLE:   start accepted -> pc=0, err=0, busy=1, go FETCH.
//  FETCH:  synchronous program memory read of mem[pc]; 1 cycle.
//  DECODE: op==0 -> DONE. nsrc==0 -> err=1, DONE. Otherwise latch cmd fields, go INIT.
//  INIT:   cmd_valid=1, cmd_type=0; hold until cmd_ready; go EVAL on handshake.
//  EVAL:   cmd_valid=1, cmd_type=1; on handshake: if pc==PD-1 go DONE
//          (implicit HALT, no wrap); else pc=pc+1, go FETCH.
//  DONE:   done=1 for exactly one cycle, busy=0 on the same cycle; go IDLE.
//  Handshake: all cmd_* outputs stay stable while cmd_valid&!cmd_ready.
//   cmd_valid never drops without a handshake, except on rst.
//  Latency with cmd_ready tied high: 4 cycles per instruction (FETCH, DECODE, INIT, EVAL).
//   A program of N gates + HALT gives start-to-done = 4N+3 cycles.
//  Edge cases:
//   - start and prog_we in the same cycle while IDLE: both take effect;
//     the write lands before the FETCH read.
//   - prog_we while busy: dropped silently.
//   - rst mid-operation: next edge returns to reset state and cmd_valid=0.
//     The crossbar must discard any partial INIT/EVAL pair.
//   - HALT at pc=0: no commands issued; done 3 cycles after start.
// CONFIGURATION
//  MAGIC_STALL_CNT_EN defined:
//   - stall_cnt increments on every cycle with cmd_valid&!cmd_ready.
//   - It saturates at 16'hFFFF and clears on an accepted start.
//  Not defined: stall_cnt is tied to 0 and no counter logic is generated.
// TESTING
//  T1 single NOR2: mem[0]={0,5,4,9,2,1}, mem[1]=HALT, ready=1 ->
//     INIT dst=9, then EVAL dst=9 src0=4 src1=5 nsrc=2; done at cycle 7.
//  T2 backpressure: T1 with ready low for 3 cycles during INIT ->
//     cmd fields held stable, EVAL follows, stall_cnt=3 (macro on) or 0 (off).
//  T3 bad nsrc: mem[0] has op=1, nsrc=0 -> no cmd_valid, err=1, done pulse;
//     the next start clears err.
//  T4 full program: PD NOR3 instructions, no HALT ->
//     exactly 2*PD handshakes, pc stops at PD-1, done once, no wrap.
//  T5 rst asserted in EVAL with ready=0 -> next cycle cmd_valid=0, busy=0, pc=0.
//     A restart reruns from pc=0.
//  T6 start/prog_we while busy -> ignored; program memory unchanged; run completes normally.

Source files
------------

// File: rtl/magic_nor_sequencer.sv
// Sequencer that replays a stored MAGIC NOR program as INIT/EVAL crossbar command pairs.
// Optional stall counter is built only when MAGIC_STALL_CNT_EN is defined.
module magic_nor_sequencer #(
    parameter  int AW  = 6,
    parameter  int PD  = 32,
    localparam int PAW = $clog2(PD),
    localparam int IW  = 3 + 4 * AW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           prog_we,
    input  logic [PAW-1:0] prog_addr,
    input  logic [IW-1:0]  prog_wdata,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [PAW-1:0] pc,
    output logic           cmd_valid,
    input  logic           cmd_ready,
    output logic           cmd_type,
    output logic [AW-1:0]  cmd_dst,
    output logic [AW-1:0]  cmd_src0,
    output logic [AW-1:0]  cmd_src1,
    output logic [AW-1:0]  cmd_src2,
    output logic [1:0]     cmd_nsrc,
    output logic [15:0]    stall_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_INIT   = 3'd3;
    localparam logic [2:0] S_EVAL   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [PAW-1:0] PC_LAST = PAW'(PD - 1);

    logic [2:0]    state_r;
    logic [IW-1:0] mem_r [PD];
    logic [IW-1:0] instr_r;

    logic          op_s;
    logic [1:0]    nsrc_s;
    logic [AW-1:0] dst_s;
    logic [AW-1:0] src0_s;
    logic [AW-1:0] src1_s;
    logic [AW-1:0] src2_s;
    logic          start_ok_s;

    assign op_s       = instr_r[0];
    assign nsrc_s     = instr_r[2:1];
    assign dst_s      = instr_r[3 +: AW];
    assign src0_s     = instr_r[3 + AW +: AW];
    assign src1_s     = instr_r[3 + 2 * AW +: AW];
    assign src2_s     = instr_r[3 + 3 * AW +: AW];
    assign start_ok_s = (state_r == S_IDLE) && start;

    // Program store: writes only while idle, single synchronous read in FETCH
    always_ff @(posedge clk) begin
        if (prog_we && !busy) begin
            mem_r[prog_addr] <= prog_wdata;
        end
        if (state_r == S_FETCH) begin
            instr_r <= mem_r[pc];
        end
    end

    // Control FSM with registered command and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            pc        <= '0;
            cmd_valid <= 1'b0;
            cmd_type  <= 1'b0;
            cmd_dst   <= '0;
            cmd_src0  <= '0;
            cmd_src1  <= '0;
            cmd_src2  <= '0;
            cmd_nsrc  <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        pc      <= '0;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_r <= S_DECODE;
                end
                S_DECODE: begin
                    if (!op_s) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else if (nsrc_s == 2'd0) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        cmd_dst   <= dst_s;
                        cmd_src0  <= src0_s;
                        cmd_src1  <= src1_s;
                        cmd_src2  <= src2_s;
                        cmd_nsrc  <= nsrc_s;
                        cmd_type  <= 1'b0;
                        cmd_valid <= 1'b1;
                        state_r   <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (cmd_ready) begin
                        cmd_type <= 1'b1;
                        state_r  <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        // Last slot acts as an implicit HALT; pc never wraps
                        if (pc == PC_LAST) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= S_DONE;
                        end else begin
                            pc      <= pc + PAW'(1);
                            state_r <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    cmd_valid <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MAGIC_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of back-pressured command cycles, cleared by an accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if (start_ok_s) begin
            stall_cnt_r <= 16'd0;
        end else if (cmd_valid && !cmd_ready && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_r;
`else
    logic unused_start_ok_s;
    assign unused_start_ok_s = start_ok_s;
    assign stall_cnt         = 16'd0;
`endif

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Self-checking bench for magic_nor_sequencer: randomized programs and back-pressure
// checked against a behavioural program-interpretation model.
module tb_magic_nor_sequencer;
    localparam int AW  = 6;
    localparam int PD  = 32;
    localparam int PAW = 5;
    localparam int IW  = 3 + 4 * AW;

    logic           clk = 1'b0;
    logic           rst, prog_we, start, cmd_ready;
    logic [PAW-1:0] prog_addr;
    logic [IW-1:0]  prog_wdata;
    logic           busy, done, err, cmd_valid, cmd_type;
    logic [PAW-1:0] pc;
    logic [AW-1:0]  cmd_dst, cmd_src0, cmd_src1, cmd_src2;
    logic [1:0]     cmd_nsrc;
    logic [15:0]    stall_cnt;

    magic_nor_sequencer #(.AW(AW), .PD(PD)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .busy(busy), .done(done), .err(err),
        .pc(pc), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_dst(cmd_dst), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_src2(cmd_src2),
        .cmd_nsrc(cmd_nsrc), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          t;
        logic [1:0]    n;
        logic [AW-1:0] dst, s0, s1, s2;
    } cmd_t;

    cmd_t          got_q[$];
    cmd_t          exp_q[$];
    logic [IW-1:0] model_mem [PD];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            done_cyc, done_cnt, stalls, stab_bad, proto_bad, exp_base, exp_pc, done_pc;
    logic          exp_err, done_err;

    function automatic logic [IW-1:0] mk(input int op, input int nsrc, input int dst,
                                         input int s0, input int s1, input int s2);
        return {AW'(s2), AW'(s1), AW'(s0), AW'(dst), 2'(nsrc), 1'(op)};
    endfunction

    // Interprets the program: every gate yields INIT then EVAL; HALT or bad nsrc ends the run
    function automatic void build_model();
        int   n = 0;
        logic halted = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        exp_pc  = PD - 1;
        for (int p = 0; p < PD; p++) begin
            logic [IW-1:0] w = model_mem[p];
            cmd_t c;
            if (w[0] == 1'b0) begin halted = 1'b1; exp_pc = p; break; end
            if (w[2:1] == 2'd0) begin halted = 1'b1; exp_err = 1'b1; exp_pc = p; break; end
            c.n = w[2:1]; c.dst = w[8:3]; c.s0 = w[14:9]; c.s1 = w[20:15]; c.s2 = w[26:21];
            c.t = 1'b0; exp_q.push_back(c);
            c.t = 1'b1; exp_q.push_back(c);
            n++;
        end
        exp_base = 4 * n + (halted ? 3 : 1);
    endfunction

    function automatic bit cmd_match(input cmd_t g, input cmd_t e);
        if (g.t !== e.t || g.dst !== e.dst) return 1'b0;
        if (e.t == 1'b0) return 1'b1;
        if (g.n !== e.n || g.s0 !== e.s0) return 1'b0;
        if (e.n >= 2'd2 && g.s1 !== e.s1) return 1'b0;
        if (e.n == 2'd3 && g.s2 !== e.s2) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int exp_stall_cnt(input int s);
`ifdef MAGIC_STALL_CNT_EN
        return (s > 65535) ? 65535 : s;
`else
        return (s < 0) ? s : 0;
`endif
    endfunction

    task automatic write_mem(input int addr, input logic [IW-1:0] data);
        prog_we = 1'b1; prog_addr = PAW'(addr); prog_wdata = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
        model_mem[addr] = data;
    endtask

    // Starts a run and monitors it; mode 0 ready high, 1 random, 2 three INIT stalls
    task automatic run(input int mode, input bit ws_en, input int ws_addr,
                       input logic [IW-1:0] ws_data, input bit poke);
        int   low_left = 3;
        bit   prev_stall = 1'b0;
        cmd_t prev, cur;
        got_q.delete();
        done_cyc = -1; done_cnt = 0; stalls = 0; stab_bad = 0; proto_bad = 0;
        start = 1'b1;
        if (ws_en) begin prog_we = 1'b1; prog_addr = PAW'(ws_addr); prog_wdata = ws_data; end
        for (int c = 0; c < 3000; c++) begin
            if (c == 1) begin start = 1'b0; prog_we = 1'b0; end
            if (poke && c == 5) begin
                start = 1'b1; prog_we = 1'b1; prog_addr = '0; prog_wdata = IW'($urandom);
            end
            if (poke && c == 6) begin start = 1'b0; prog_we = 1'b0; end
            case (mode)
                1: cmd_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    cmd_ready = !(cmd_valid && !cmd_type && low_left > 0);
                    if (!cmd_ready) low_left--;
                end
                default: cmd_ready = 1'b1;
            endcase
            cur = {cmd_type, cmd_nsrc, cmd_dst, cmd_src0, cmd_src1, cmd_src2};
            if (prev_stall && (!cmd_valid || cur !== prev)) stab_bad++;
            prev_stall = cmd_valid && !cmd_ready;
            prev = cur;
            if (cmd_valid && !cmd_ready) stalls++;
            if (cmd_valid && cmd_ready) got_q.push_back(cur);
            if (done && busy) proto_bad++;
            if (c >= 1 && done_cyc < 0 && !done && !busy) proto_bad++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = c; done_pc = pc; done_err = err; end
            end
            if (done_cyc >= 0 && c >= done_cyc + 3) break;
            @(posedge clk); #1;
        end
        cmd_ready = 1'b1;
        if (done_cyc < 0) begin
            n_checks++; n_fail++;
            $display("FAIL run_timeout: done never seen, required within 3000 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; cmd_ready = 1'b1;
        prog_addr = '0; prog_wdata = '0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        n_checks++;
        if ({busy, done, err, cmd_valid, cmd_type, pc, stall_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b done=%b err=%b valid=%b type=%b pc=%0d stall=%0d, required all 0",
                     busy, done, err, cmd_valid, cmd_type, pc, stall_cnt);
        end
        n_checks++;
        if ({cmd_dst, cmd_src0, cmd_src1, cmd_src2, cmd_nsrc} !== '0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h, required 0",
                     {cmd_dst, cmd_src0, cmd_src1, cmd_src2, cmd_nsrc});
        end
    endtask

    task automatic test_single_nor2();
        write_mem(1, mk(0, 0, 0, 0, 0, 0));
        model_mem[0] = mk(1, 2, 9, 4, 5, 0);
        run(0, 1'b1, 0, mk(1, 2, 9, 4, 5, 0), 1'b0);
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++; $display("FAIL t1_count: got %0d commands, required 2", got_q.size());
        end else begin
            n_checks++;
            if (got_q[0].t !== 1'b0 || got_q[0].dst !== 6'd9) begin
                n_fail++; $display("FAIL t1_init: got type=%b dst=%0d, required type=0 dst=9",
                                   got_q[0].t, got_q[0].dst);
            end
            n_checks++;
            if (got_q[1].t !== 1'b1 || got_q[1].dst !== 6'd9 || got_q[1].s0 !== 6'd4 ||
                got_q[1].s1 !== 6'd5 || got_q[1].n !== 2'd2) begin
                n_fail++; $display("FAIL t1_eval: got %h, required type=1 dst=9 s0=4 s1=5 n=2",
                                   got_q[1]);
            end
        end
        n_checks++;
        if (done_cyc != 7 || done_cnt != 1) begin
            n_fail++; $display("FAIL t1_done: got cycle %0d count %0d, required cycle 7 count 1",
                               done_cyc, done_cnt);
        end
    endtask

    task automatic test_backpressure();
        build_model();
        run(2, 1'b0, 0, '0, 1'b0);
        n_checks++;
        if (stab_bad != 0 || stalls != 3) begin
            n_fail++; $display("FAIL t2_stall: got unstable=%0d stalls=%0d, required 0 and 3",
                               stab_bad, stalls);
        end
        n_checks++;
        if (got_q.size() != 2 || !cmd_match(got_q[0], exp_q[0]) || !cmd_match(got_q[1], exp_q[1])) begin
            n_fail++; $display("FAIL t2_cmds: got %0d commands, required INIT/EVAL pair for dst 9",
                               got_q.size());
        end
        n_checks++;
        if (done_cyc != 10) begin
            n_fail++; $display("FAIL t2_done: got cycle %0d, required 10", done_cyc);
        end
        n_checks++;
        if (int'(stall_cnt) != exp_stall_cnt(3)) begin
            n_fail++; $display("FAIL t2_stall_cnt: got %0d, required %0d", stall_cnt, exp_stall_cnt(3));
        end
    endtask

    task automatic test_bad_nsrc();
        write_mem(0, mk(1, 0, 3, 1, 2, 3));
        run(0, 1'b0, 0, '0, 1'b0);
        n_checks++;
        if (got_q.size() != 0 || done_err !== 1'b1 || done_cyc != 3 || done_cnt != 1) begin
            n_fail++; $display("FAIL t3_bad: got cmds=%0d err=%b cycle=%0d count=%0d, required 0 1 3 1",
                               got_q.size(), done_err, done_cyc, done_cnt);
        end
        write_mem(0, mk(1, 1, 7, 2, 0, 0));
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL t3_sticky: got err=%b, required 1", err);
        end
        build_model();
        run(0, 1'b0, 0, '0, 1'b0);
        n_checks++;
        if (done_err !== 1'b0 || err !== 1'b0 || got_q.size() != 2 || done_cyc != exp_base) begin
            n_fail++; $display("FAIL t3_clear: got err=%b cmds=%0d cycle=%0d, required 0 2 %0d",
                               err, got_q.size(), done_cyc, exp_base);
        end
    endtask

    task automatic test_full_program();
        int bad = 0;
        for (int p = 0; p < PD; p++)
            write_mem(p, mk(1, 3, $urandom_range(0, 63), $urandom_range(0, 63),
                            $urandom_range(0, 63), $urandom_range(0, 63)));
        build_model();
        run(1, 1'b0, 0, '0, 1'b0);
        n_checks++;
        if (got_q.size() != 2 * PD) begin
            n_fail++; $display("FAIL t4_count: got %0d handshakes, required %0d", got_q.size(), 2 * PD);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (!cmd_match(got_q[i], exp_q[i])) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL t4_cmds: got %0d mismatching commands, required 0", bad);
        end
        n_checks++;
        if (done_cnt != 1 || done_pc != PD - 1 || done_cyc != 4 * PD + 1 + stalls) begin
            n_fail++; $display("FAIL t4_done: got count=%0d pc=%0d cycle=%0d, required 1 %0d %0d",
                               done_cnt, done_pc, done_cyc, PD - 1, 4 * PD + 1 + stalls);
        end
        n_checks++;
        if (stab_bad != 0 || proto_bad != 0 || int'(stall_cnt) != exp_stall_cnt(stalls)) begin
            n_fail++; $display("FAIL t4_proto: got unstable=%0d proto=%0d stall_cnt=%0d, required 0 0 %0d",
                               stab_bad, proto_bad, stall_cnt, exp_stall_cnt(stalls));
        end
    endtask

    task automatic test_rst_mid();
        bit in_eval = 1'b0;
        write_mem(0, mk(1, 2, 12, 30, 31, 0));
        write_mem(1, mk(0, 0, 0, 0, 0, 0));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50; c++) begin
            cmd_ready = !(cmd_valid && cmd_type);
            if (cmd_valid && cmd_type) begin in_eval = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; cmd_ready = 1'b1;
        n_checks++;
        if (!in_eval || cmd_valid !== 1'b0 || busy !== 1'b0 || pc !== '0 || done !== 1'b0) begin
            n_fail++; $display("FAIL t5_rst: got eval_seen=%b valid=%b busy=%b pc=%0d done=%b, required 1 0 0 0 0",
                               in_eval, cmd_valid, busy, pc, done);
        end
        build_model();
        run(0, 1'b0, 0, '0, 1'b0);
        n_checks++;
        if (got_q.size() != 2 || !cmd_match(got_q[0], exp_q[0]) || !cmd_match(got_q[1], exp_q[1]) ||
            done_cyc != 7) begin
            n_fail++; $display("FAIL t5_restart: got cmds=%0d cycle=%0d, required 2 7", got_q.size(), done_cyc);
        end
    endtask

    task automatic test_busy_ignored();
        int bad = 0;
        for (int p = 0; p < 3; p++)
            write_mem(p, mk(1, $urandom_range(1, 3), $urandom_range(0, 63), $urandom_range(0, 63),
                            $urandom_range(0, 63), $urandom_range(0, 63)));
        write_mem(3, mk(0, 0, 0, 0, 0, 0));
        build_model();
        for (int r = 0; r < 2; r++) begin
            run(0, 1'b0, 0, '0, (r == 0));
            bad = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                if (!cmd_match(got_q[i], exp_q[i])) bad++;
            n_checks++;
            if (bad != 0 || got_q.size() != 6 || done_cnt != 1 || done_cyc != exp_base) begin
                n_fail++; $display("FAIL t6_run%0d: got bad=%0d cmds=%0d count=%0d cycle=%0d, required 0 6 1 %0d",
                                   r, bad, got_q.size(), done_cnt, done_cyc, exp_base);
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int len = $urandom_range(1, 12);
            int bad = 0;
            for (int p = 0; p < len; p++)
                write_mem(p, mk(1, ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 3),
                                $urandom_range(0, 63), $urandom_range(0, 63),
                                $urandom_range(0, 63), $urandom_range(0, 63)));
            write_mem(len, mk(0, $urandom_range(0, 3), 0, 0, 0, 0));
            build_model();
            run(1, 1'b0, 0, '0, 1'b0);
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
                if (!cmd_match(got_q[i], exp_q[i])) bad++;
            n_checks++;
            if (bad != 0 || got_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_cmds: got bad=%0d cmds=%0d, required 0 %0d",
                                   it, bad, got_q.size(), exp_q.size());
            end
            n_checks++;
            if (done_cyc != exp_base + stalls || done_err !== exp_err || done_pc != exp_pc ||
                stab_bad != 0 || proto_bad != 0 || int'(stall_cnt) != exp_stall_cnt(stalls)) begin
                n_fail++; $display("FAIL rand%0d_status: got cycle=%0d err=%b pc=%0d unstable=%0d proto=%0d stall_cnt=%0d, required %0d %b %0d 0 0 %0d",
                                   it, done_cyc, done_err, done_pc, stab_bad, proto_bad, stall_cnt,
                                   exp_base + stalls, exp_err, exp_pc, exp_stall_cnt(stalls));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_nor2();
        test_backpressure();
        test_bad_nsrc();
        test_full_program();
        test_rst_mid();
        test_busy_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
